// File: rtl/branch_resolve_queue_pkg.sv
// Shared constants for the branch-resolve path, common to fetch, execute and the
// resolve queue.
package bp_pkg;

    localparam int BP_DEPTH_DEF = 4;
    localparam int BP_CNT_W_DEF = 16;

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int bp_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/statistics bundle of the branch resolve queue. The master side
// drives fetch pushes and execute resolves, and the slave side is the queue.
interface branch_resolve_queue_if
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int CNT_W = BP_CNT_W_DEF
);
    localparam int CW = bp_count_w(DEPTH);

    logic             push;
    logic             pred_in;
    logic             full;
    logic             empty;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pred_in, resolve_valid, resolve_taken,
        input  full, empty, result, taken, mispredict, count,
               resolved_cnt, mispred_cnt, overflow, underflow
    );

    modport slave (
        input  push, pred_in, resolve_valid, resolve_taken,
        output full, empty, result, taken, mispredict, count,
               resolved_cnt, mispred_cnt, overflow, underflow
    );

endinterface

// File: rtl/branch_resolve_queue_pred_fifo.sv
// One-bit ring buffer of predicted directions. It supports push, pop and a
// flush that empties the buffer in the same cycle as the pop that caused it.
module pred_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = BP_DEPTH_DEF,
    localparam int CW    = bp_count_w(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          din,
    output logic          head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic             wr_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign rd_next = rd_ptr + PW'(pop);
    // A flushing cycle discards its own push because that fetch is on the wrong path.
    assign wr_en   = push && (!full || pop) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= rd_next;
            wr_ptr <= rd_next;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    // NOTE: storage has no reset; an entry is only read after it is written, and the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction tracker. It compares each stored prediction with
// the execute outcome, trains the predictor, flushes on a mispredict and counts
// events.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int CNT_W = BP_CNT_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    branch_resolve_queue_if.slave bus
);

    localparam int CW = bp_count_w(DEPTH);

    logic          head;
    logic          pop;
    logic          mismatch;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    assign pop      = bus.resolve_valid && !empty;
    assign mismatch = pop && (head != bus.resolve_taken);

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push),
        .pop   (pop),
        .flush (mismatch),
        .din   (bus.pred_in),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result       <= 1'b0;
            bus.taken        <= 1'b0;
            bus.mispredict   <= 1'b0;
            bus.resolved_cnt <= '0;
            bus.mispred_cnt  <= '0;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            bus.result     <= pop;
            bus.mispredict <= mismatch;
            if (pop) begin
                bus.taken <= bus.resolve_taken;
            end
            // Statistics saturate at their maximum value instead of wrapping to zero.
            if (pop && (bus.resolved_cnt != '1)) begin
                bus.resolved_cnt <= bus.resolved_cnt + CNT_W'(1);
            end
            if (mismatch && (bus.mispred_cnt != '1)) begin
                bus.mispred_cnt <= bus.mispred_cnt + CNT_W'(1);
            end
            if (bus.push && full && !pop) begin
                bus.overflow <= 1'b1;
            end
            if (bus.resolve_valid && empty) begin
                bus.underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: table of per-cycle vectors, then
// hand-written wrap, reset and saturation sequences.
module tb_branch_resolve_queue;

    typedef struct {
        logic [4:0]  in;     // rst, push, pred, rv, rt
        logic [2:0]  cnt;
        logic [4:0]  flags;  // full, empty, result, taken, mispredict
        logic [15:0] rc;
        logic [15:0] mc;
        logic [1:0]  ovun;   // overflow, underflow
    } vec_t;

    localparam int NV = 28;

    logic clk;
    logic rst;
    logic rst2;
    int   total;
    int   bad;
    vec_t vecs [NV];

    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(16)) bus ();
    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(2))  bus2 ();

    branch_resolve_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    branch_resolve_queue #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] cnt,
                                input logic [4:0] flags, input logic [15:0] rc,
                                input logic [15:0] mc, input logic [1:0] ovun);
        vec_t v;
        v.in = in; v.cnt = cnt; v.flags = flags; v.rc = rc; v.mc = mc; v.ovun = ovun;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic pd, input logic rv, input logic rt);
        rst               = r;
        bus.push          = p;
        bus.pred_in       = pd;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic r, input logic p, input logic pd, input logic rv, input logic rt);
        rst2               = r;
        bus2.push          = p;
        bus2.pred_in       = pd;
        bus2.resolve_valid = rv;
        bus2.resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          q[$];
        bit          head;
        bit          exp_mis;
        bit          exp_res;
        bit          exp_tk;
        logic [9:0]  preds;
        logic [9:0]  rts;
        int          exp_rc;
        int          exp_mc;
        logic        rv;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rst2  = 1'b1;
        bus.push = 1'b0; bus.pred_in = 1'b0; bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
        bus2.push = 1'b0; bus2.pred_in = 1'b0; bus2.resolve_valid = 1'b0; bus2.resolve_taken = 1'b0;

        //             in(r,p,pd,rv,rt) cnt   flags(f,e,res,tk,mp) rc     mc     ov,un
        vecs[0]  = mk(5'b10000, 3'd0, 5'b01000, 16'd0, 16'd0, 2'b00); // reset state
        vecs[1]  = mk(5'b01100, 3'd1, 5'b00000, 16'd0, 16'd0, 2'b00); // push 1
        vecs[2]  = mk(5'b01000, 3'd2, 5'b00000, 16'd0, 16'd0, 2'b00); // push 0
        vecs[3]  = mk(5'b01100, 3'd3, 5'b00000, 16'd0, 16'd0, 2'b00); // push 1
        vecs[4]  = mk(5'b01100, 3'd4, 5'b10000, 16'd0, 16'd0, 2'b00); // push 1 -> full
        vecs[5]  = mk(5'b01000, 3'd4, 5'b10000, 16'd0, 16'd0, 2'b10); // overflow
        vecs[6]  = mk(5'b00011, 3'd3, 5'b00110, 16'd1, 16'd0, 2'b10); // resolve 1
        vecs[7]  = mk(5'b00010, 3'd2, 5'b00100, 16'd2, 16'd0, 2'b10); // resolve 0
        vecs[8]  = mk(5'b00011, 3'd1, 5'b00110, 16'd3, 16'd0, 2'b10); // resolve 1
        vecs[9]  = mk(5'b00011, 3'd0, 5'b01110, 16'd4, 16'd0, 2'b10); // resolve 1 -> empty
        vecs[10] = mk(5'b00000, 3'd0, 5'b01010, 16'd4, 16'd0, 2'b10); // idle, taken holds
        vecs[11] = mk(5'b01100, 3'd1, 5'b00010, 16'd4, 16'd0, 2'b10);
        vecs[12] = mk(5'b01100, 3'd2, 5'b00010, 16'd4, 16'd0, 2'b10);
        vecs[13] = mk(5'b01000, 3'd3, 5'b00010, 16'd4, 16'd0, 2'b10);
        vecs[14] = mk(5'b01110, 3'd0, 5'b01101, 16'd5, 16'd1, 2'b10); // mispredict + push flushed
        vecs[15] = mk(5'b00000, 3'd0, 5'b01000, 16'd5, 16'd1, 2'b10);
        vecs[16] = mk(5'b10000, 3'd0, 5'b01000, 16'd0, 16'd0, 2'b00); // reset clears sticky
        vecs[17] = mk(5'b01000, 3'd1, 5'b00000, 16'd0, 16'd0, 2'b00);
        vecs[18] = mk(5'b01100, 3'd2, 5'b00000, 16'd0, 16'd0, 2'b00);
        vecs[19] = mk(5'b01000, 3'd3, 5'b00000, 16'd0, 16'd0, 2'b00);
        vecs[20] = mk(5'b01000, 3'd4, 5'b10000, 16'd0, 16'd0, 2'b00);
        vecs[21] = mk(5'b01110, 3'd4, 5'b10100, 16'd1, 16'd0, 2'b00); // full push+pop
        vecs[22] = mk(5'b00011, 3'd3, 5'b00110, 16'd2, 16'd0, 2'b00);
        vecs[23] = mk(5'b00010, 3'd2, 5'b00100, 16'd3, 16'd0, 2'b00);
        vecs[24] = mk(5'b00010, 3'd1, 5'b00100, 16'd4, 16'd0, 2'b00);
        vecs[25] = mk(5'b00011, 3'd0, 5'b01110, 16'd5, 16'd0, 2'b00); // late push read last
        vecs[26] = mk(5'b00010, 3'd0, 5'b01010, 16'd5, 16'd0, 2'b01); // underflow
        vecs[27] = mk(5'b00000, 3'd0, 5'b01010, 16'd5, 16'd0, 2'b01);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
            check($sformatf("v%0d.count", i), 32'(bus.count), 32'(vecs[i].cnt));
            check($sformatf("v%0d.flags", i),
                  32'({bus.full, bus.empty, bus.result, bus.taken, bus.mispredict}),
                  32'(vecs[i].flags));
            check($sformatf("v%0d.resolved_cnt", i), 32'(bus.resolved_cnt), 32'(vecs[i].rc));
            check($sformatf("v%0d.mispred_cnt", i), 32'(bus.mispred_cnt), 32'(vecs[i].mc));
            check($sformatf("v%0d.ovun", i), 32'({bus.overflow, bus.underflow}), 32'(vecs[i].ovun));
        end

        // Wrap: keep at most two branches in flight across ten push/resolve cycles.
        preds  = 10'b1101001011;
        rts    = 10'b1100101011;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        q.push_back(1'b1);
        exp_rc = 0;
        exp_mc = 0;
        exp_tk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rv = (q.size() > 0);
            step(1'b0, 1'b1, preds[i], rv, rts[i]);
            exp_mis = 1'b0;
            exp_res = 1'b0;
            if (rv) begin
                head    = q.pop_front();
                exp_res = 1'b1;
                exp_tk  = rts[i];
                exp_mis = (head != rts[i]);
                exp_rc++;
                if (exp_mis) begin
                    exp_mc++;
                    q.delete();
                end else begin
                    q.push_back(preds[i]);
                end
            end else begin
                q.push_back(preds[i]);
            end
            check($sformatf("wrap%0d.result", i), 32'(bus.result), 32'(exp_res));
            check($sformatf("wrap%0d.mispredict", i), 32'(bus.mispredict), 32'(exp_mis));
            check($sformatf("wrap%0d.taken", i), 32'(bus.taken), 32'(exp_tk));
            check($sformatf("wrap%0d.count", i), 32'(bus.count), 32'(q.size()));
            check($sformatf("wrap%0d.resolved_cnt", i), 32'(bus.resolved_cnt), 32'(exp_rc));
            check($sformatf("wrap%0d.mispred_cnt", i), 32'(bus.mispred_cnt), 32'(exp_mc));
        end

        // Reset in the middle of traffic drops everything at once.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst.count", 32'(bus.count), 32'd0);
        check("midrst.flags",
              32'({bus.full, bus.empty, bus.result, bus.taken, bus.mispredict}), 32'b01000);
        check("midrst.counters", {bus.resolved_cnt, bus.mispred_cnt}, 32'd0);
        check("midrst.ovun", 32'({bus.overflow, bus.underflow}), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("postrst.count", 32'(bus.count), 32'd0);

        // Saturation on a 2-bit counter instance.
        step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step2(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            step2(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        check("sat.resolved_cnt", 32'(bus2.resolved_cnt), 32'd3);
        check("sat.mispred_cnt0", 32'(bus2.mispred_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step2(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step2(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        check("sat.mispred_cnt", 32'(bus2.mispred_cnt), 32'd3);
        check("sat.resolved_hold", 32'(bus2.resolved_cnt), 32'd3);
        check("sat.count", 32'(bus2.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
